// File: rtl/pc_unit_ras.sv
// Program counter with branch/jump/call/return and a circular return-address stack.
// Latency: one cycle; the new PC, taken flag, RAS count and faults are visible after the rising edge.
// Backpressure: input_PCWrite=0 freezes all state and clears output_taken; there is no other stall path.
//
// Ports:
//   CLK, input_rst_n          clock, synchronous active-low reset
//   input_PCWrite, input_op   update enable and operation (SEQ/BRANCH/JUMP/CALL/RET, rest act as SEQ)
//   input_newPC               unscaled target, shifted left by TARGET_SHIFT
//   input_zero/negative       ALU flags for the branch condition selected by input_branchType
//   output_PC, output_taken   registered PC and one-cycle redirect indication
//   output_ras_count/full/empty  RAS occupancy (full/empty decoded from the registered count)
//   output_fault              sticky {underflow, overflow}
module pc_unit_ras #(
  parameter int WIDTH        = 16,
  parameter int STEP         = 2,
  parameter int TARGET_SHIFT = 1,
  parameter int RAS_DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                         CLK,
  input  logic                         input_rst_n,
  input  logic                         input_PCWrite,
  input  logic [2:0]                   input_op,
  input  logic [WIDTH-1:0]             input_newPC,
  input  logic                         input_zero,
  input  logic                         input_negative,
  input  logic [1:0]                   input_branchType,
  output logic [WIDTH-1:0]             output_PC,
  output logic                         output_taken,
  output logic [$clog2(RAS_DEPTH):0]   output_ras_count,
  output logic                         output_ras_full,
  output logic                         output_ras_empty,
  output logic [1:0]                   output_fault
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  localparam logic [2:0] OP_SEQ    = 3'b000;
  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;

  localparam logic [1:0] BR_EQ = 2'b00;
  localparam logic [1:0] BR_NE = 2'b01;
  localparam logic [1:0] BR_LT = 2'b10;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             taken_q, taken_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [1:0]       fault_q, fault_d;

  logic [WIDTH-1:0] ras [RAS_DEPTH];

  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] target_pc;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_dec;
  logic             cond;
  logic             push;
  logic             ras_full;
  logic             ras_empty;

  assign seq_pc    = pc_q + WIDTH'(STEP);
  assign target_pc = input_newPC << TARGET_SHIFT;

  // Explicit wrap so non-power-of-two depths stay circular.
  assign ptr_inc = (ptr_q == PTR_MAX) ? '0 : ptr_q + PTR_W'(1);
  assign ptr_dec = (ptr_q == '0) ? PTR_MAX : ptr_q - PTR_W'(1);

  assign ras_full  = (cnt_q == CNT_MAX);
  assign ras_empty = (cnt_q == '0);

  always_comb begin
    cond = 1'b0;
    case (input_branchType)
      BR_EQ:   cond = input_zero;
      BR_NE:   cond = !input_zero;
      BR_LT:   cond = input_negative;
      default: cond = !input_negative;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    taken_d = 1'b0;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    fault_d = fault_q;
    push    = 1'b0;
    if (input_PCWrite) begin
      case (input_op)
        OP_BRANCH: begin
          pc_d    = cond ? target_pc : seq_pc;
          taken_d = cond;
        end
        OP_JUMP: begin
          pc_d    = target_pc;
          taken_d = 1'b1;
        end
        OP_CALL: begin
          push    = 1'b1;
          pc_d    = target_pc;
          taken_d = 1'b1;
          ptr_d   = ptr_inc;
          // A push into a full stack overwrites the oldest entry; count saturates.
          if (ras_full) fault_d[0] = 1'b1;
          else          cnt_d      = cnt_q + CNT_W'(1);
        end
        OP_RET: begin
          if (ras_empty) begin
            pc_d       = seq_pc;
            fault_d[1] = 1'b1;
          end else begin
            pc_d    = ras[ptr_dec];
            ptr_d   = ptr_dec;
            cnt_d   = cnt_q - CNT_W'(1);
            taken_d = 1'b1;
          end
        end
        default: pc_d = seq_pc;  // SEQ and reserved encodings
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!input_rst_n) begin
      pc_q    <= RESET_PC;
      taken_q <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      fault_q <= '0;
    end else begin
      pc_q    <= pc_d;
      taken_q <= taken_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      fault_q <= fault_d;
    end
  end

  // Stack storage needs no reset; entries are only read once count says they are valid.
  always_ff @(posedge CLK) begin
    if (input_rst_n && push) ras[ptr_q] <= seq_pc;
  end

  assign output_PC        = pc_q;
  assign output_taken     = taken_q;
  assign output_ras_count = cnt_q;
  assign output_ras_full  = ras_full;
  assign output_ras_empty = ras_empty;
  assign output_fault     = fault_q;

endmodule

// File: tb/tb_pc_unit_ras.sv
module tb_pc_unit_ras;

  localparam logic [2:0] SEQ = 3'b000;
  localparam logic [2:0] BR  = 3'b001;
  localparam logic [2:0] JMP = 3'b010;
  localparam logic [2:0] CAL = 3'b011;
  localparam logic [2:0] RET = 3'b100;
  localparam logic [2:0] RSV = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write;
  logic [2:0]  op;
  logic [15:0] new_pc;
  logic        zero;
  logic        negative;
  logic [1:0]  branch_type;
  logic [15:0] pc;
  logic        taken;
  logic [2:0]  ras_count;
  logic        ras_full;
  logic        ras_empty;
  logic [1:0]  fault;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pc_unit_ras dut (
    .CLK              (clk),
    .input_rst_n      (rst_n),
    .input_PCWrite    (pc_write),
    .input_op         (op),
    .input_newPC      (new_pc),
    .input_zero       (zero),
    .input_negative   (negative),
    .input_branchType (branch_type),
    .output_PC        (pc),
    .output_taken     (taken),
    .output_ras_count (ras_count),
    .output_ras_full  (ras_full),
    .output_ras_empty (ras_empty),
    .output_fault     (fault)
  );

  typedef struct {
    logic        rst_n;
    logic        wr;
    logic [2:0]  op;
    logic [15:0] npc;
    logic        z;
    logic        n;
    logic [1:0]  bt;
    logic [15:0] e_pc;
    logic        e_taken;
    logic [2:0]  e_cnt;
    logic        e_full;
    logic        e_empty;
    logic [1:0]  e_fault;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic w, input logic [2:0] o, input logic [15:0] np,
                     input logic z, input logic n, input logic [1:0] bt,
                     input logic [15:0] epc, input logic et, input logic [2:0] ec,
                     input logic ef, input logic ee, input logic [1:0] eflt);
    vec_t v;
    v.rst_n = r; v.wr = w; v.op = o; v.npc = np; v.z = z; v.n = n; v.bt = bt;
    v.e_pc = epc; v.e_taken = et; v.e_cnt = ec; v.e_full = ef; v.e_empty = ee; v.e_fault = eflt;
    tbl.push_back(v);
  endtask

  // Drive one vector, let one rising edge pass, then sample 1 time unit later.
  task automatic apply(input vec_t v, input string name);
    rst_n = v.rst_n; pc_write = v.wr; op = v.op; new_pc = v.npc;
    zero = v.z; negative = v.n; branch_type = v.bt;
    @(posedge clk);
    #1;
    vectors++;
    if (pc !== v.e_pc || taken !== v.e_taken || ras_count !== v.e_cnt ||
        ras_full !== v.e_full || ras_empty !== v.e_empty || fault !== v.e_fault) begin
      miscompares++;
      $display("FAIL %s: got pc=%h taken=%b cnt=%0d full=%b empty=%b fault=%b, want pc=%h taken=%b cnt=%0d full=%b empty=%b fault=%b",
               name, pc, taken, ras_count, ras_full, ras_empty, fault,
               v.e_pc, v.e_taken, v.e_cnt, v.e_full, v.e_empty, v.e_fault);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [2:0] o, input logic [15:0] np,
                      input logic [15:0] epc, input logic et, input logic [2:0] ec,
                      input logic ef, input logic ee, input logic [1:0] eflt, input string name);
    vec_t v;
    v.rst_n = r; v.wr = w; v.op = o; v.npc = np; v.z = 1'b0; v.n = 1'b0; v.bt = 2'b00;
    v.e_pc = epc; v.e_taken = et; v.e_cnt = ec; v.e_full = ef; v.e_empty = ee; v.e_fault = eflt;
    apply(v, name);
  endtask

  initial begin
    rst_n = 1'b0; pc_write = 1'b0; op = SEQ; new_pc = '0;
    zero = 1'b0; negative = 1'b0; branch_type = 2'b00;

    //   rst wr op   newPC    z  n  bt      PC       tk cnt full empty fault
    add(0, 1, CAL, 16'h1111, 0, 0, 2'b00, 16'h0000, 0, 0, 0, 1, 2'b00); // reset
    add(1, 1, SEQ, 16'h0000, 0, 0, 2'b00, 16'h0002, 0, 0, 0, 1, 2'b00);
    add(1, 1, SEQ, 16'h0000, 0, 0, 2'b00, 16'h0004, 0, 0, 0, 1, 2'b00);
    add(1, 1, SEQ, 16'h0000, 0, 0, 2'b00, 16'h0006, 0, 0, 0, 1, 2'b00);
    add(1, 0, JMP, 16'h0100, 0, 0, 2'b00, 16'h0006, 0, 0, 0, 1, 2'b00); // hold
    add(1, 0, SEQ, 16'h0000, 0, 0, 2'b00, 16'h0006, 0, 0, 0, 1, 2'b00); // hold
    add(1, 1, JMP, 16'h0008, 0, 0, 2'b00, 16'h0010, 1, 0, 0, 1, 2'b00);
    add(1, 1, BR,  16'h1234, 1, 0, 2'b00, 16'h2468, 1, 0, 0, 1, 2'b00); // beq taken
    add(1, 1, BR,  16'h1234, 1, 0, 2'b01, 16'h246A, 0, 0, 0, 1, 2'b00); // bne not taken
    add(1, 1, BR,  16'h0100, 0, 1, 2'b10, 16'h0200, 1, 0, 0, 1, 2'b00); // blt taken
    add(1, 1, BR,  16'h0500, 0, 1, 2'b11, 16'h0202, 0, 0, 0, 1, 2'b00); // bge not taken
    add(1, 1, BR,  16'h0300, 0, 0, 2'b11, 16'h0600, 1, 0, 0, 1, 2'b00); // bge taken
    add(1, 1, BR,  16'h1111, 0, 1, 2'b00, 16'h0602, 0, 0, 0, 1, 2'b00); // beq not taken
    add(1, 1, BR,  16'h1111, 1, 0, 2'b10, 16'h0604, 0, 0, 0, 1, 2'b00); // blt not taken
    add(1, 1, RSV, 16'h1111, 0, 0, 2'b00, 16'h0606, 0, 0, 0, 1, 2'b00); // reserved = SEQ
    add(1, 1, JMP, 16'h7FFF, 0, 0, 2'b00, 16'hFFFE, 1, 0, 0, 1, 2'b00);
    add(1, 1, SEQ, 16'h0000, 0, 0, 2'b00, 16'h0000, 0, 0, 0, 1, 2'b00); // wrap
    add(1, 1, JMP, 16'h0080, 0, 0, 2'b00, 16'h0100, 1, 0, 0, 1, 2'b00);
    add(1, 1, CAL, 16'h0200, 0, 0, 2'b00, 16'h0400, 1, 1, 0, 0, 2'b00);
    add(1, 1, CAL, 16'h0300, 0, 0, 2'b00, 16'h0600, 1, 2, 0, 0, 2'b00);
    add(1, 0, CAL, 16'h0700, 0, 0, 2'b00, 16'h0600, 0, 2, 0, 0, 2'b00); // hold blocks push
    add(1, 1, RET, 16'h0000, 0, 0, 2'b00, 16'h0402, 1, 1, 0, 0, 2'b00);
    add(1, 1, RET, 16'h0000, 0, 0, 2'b00, 16'h0102, 1, 0, 0, 1, 2'b00);
    add(1, 1, JMP, 16'h0000, 0, 0, 2'b00, 16'h0000, 1, 0, 0, 1, 2'b00);
    add(1, 1, CAL, 16'h0010, 0, 0, 2'b00, 16'h0020, 1, 1, 0, 0, 2'b00);
    add(1, 1, CAL, 16'h0020, 0, 0, 2'b00, 16'h0040, 1, 2, 0, 0, 2'b00);
    add(1, 1, CAL, 16'h0030, 0, 0, 2'b00, 16'h0060, 1, 3, 0, 0, 2'b00);
    add(1, 1, CAL, 16'h0040, 0, 0, 2'b00, 16'h0080, 1, 4, 1, 0, 2'b00); // full, no fault yet
    add(1, 1, CAL, 16'h0050, 0, 0, 2'b00, 16'h00A0, 1, 4, 1, 0, 2'b01); // overflow
    add(1, 1, RET, 16'h0000, 0, 0, 2'b00, 16'h0082, 1, 3, 0, 0, 2'b01);
    add(1, 1, RET, 16'h0000, 0, 0, 2'b00, 16'h0062, 1, 2, 0, 0, 2'b01);
    add(1, 1, RET, 16'h0000, 0, 0, 2'b00, 16'h0042, 1, 1, 0, 0, 2'b01);
    add(1, 1, RET, 16'h0000, 0, 0, 2'b00, 16'h0022, 1, 0, 0, 1, 2'b01);
    add(1, 1, RET, 16'h0000, 0, 0, 2'b00, 16'h0024, 0, 0, 0, 1, 2'b11); // underflow
    add(1, 0, RET, 16'h0000, 0, 0, 2'b00, 16'h0024, 0, 0, 0, 1, 2'b11); // faults sticky
    add(1, 1, SEQ, 16'h0000, 0, 0, 2'b00, 16'h0026, 0, 0, 0, 1, 2'b11);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset landing in the middle of a CALL sequence wipes PC, stack and faults.
    step(0, 0, SEQ, 16'h0000, 16'h0000, 0, 0, 0, 1, 2'b00, "seq_reset");
    step(1, 1, CAL, 16'h0010, 16'h0020, 1, 1, 0, 0, 2'b00, "seq_call1");
    step(1, 1, CAL, 16'h0020, 16'h0040, 1, 2, 0, 0, 2'b00, "seq_call2");
    step(0, 1, CAL, 16'h0030, 16'h0000, 0, 0, 0, 1, 2'b00, "seq_rst_mid_call");
    step(1, 1, RET, 16'h0000, 16'h0002, 0, 0, 0, 1, 2'b10, "seq_ret_underflow");

    // Circular overwrite across the pointer wrap: six pushes keep only the newest four.
    step(0, 0, SEQ, 16'h0000, 16'h0000, 0, 0, 0, 1, 2'b00, "wrap_reset");
    for (int k = 1; k <= 6; k++)
      step(1, 1, CAL, 16'(k * 16'h0100), 16'(k * 16'h0200), 1, (k >= 4) ? 3'd4 : 3'(k),
           (k >= 4), 0, (k >= 5) ? 2'b01 : 2'b00, $sformatf("wrap_call%0d", k));
    // Return addresses: pushed seq of previous PC, i.e. (k-1)*0x200 + 2 for k = 6,5,4,3.
    for (int k = 6; k >= 3; k--)
      step(1, 1, RET, 16'h0000, 16'((k - 1) * 16'h0200 + 2), 1, 3'(k - 3), 0, (k == 3), 2'b01,
           $sformatf("wrap_ret%0d", k));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_unit_ras.md
Name: pc_unit_ras

Overview:
- Parametrised next-generation program counter for the multi-cycle datapath.
- Generalises PC width, increment step and target scaling, and supports four branch conditions plus jump, call and return.
- Adds a return-address stack (RAS) of configurable depth, with overflow/underflow tracking.
- Sits between the control FSM (which supplies the op and write enable) and instruction memory (which is addressed by output_PC).

Parameters:
WIDTH, 16, PC and target width in bits
STEP, 2, sequential increment in bytes
TARGET_SHIFT, 1, left shift applied to input_newPC to form a target address
RAS_DEPTH, 4, number of RAS entries (>=2)
RESET_PC, 0, PC value loaded on reset

Ports:
CLK  input  1  clock; all state updates on rising edge
input_rst_n  input  1  synchronous active-low reset
input_PCWrite  input  1  update enable; 0 = hold all state
input_op  input  3  000 SEQ, 001 BRANCH, 010 JUMP, 011 CALL, 100 RET, 101-111 reserved
input_newPC  input  WIDTH  unscaled target
input_zero  input  1  ALU zero flag
input_negative  input  1  ALU negative flag
input_branchType  input  2  00 beq, 01 bne, 10 blt, 11 bge
output_PC  output  WIDTH  current PC (registered)
output_taken  output  1  registered; 1 for one cycle after a redirecting update
output_ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries
output_ras_full  output  1  count == RAS_DEPTH (combinational from count)
output_ras_empty  output  1  count == 0 (combinational from count)
output_fault  output  2  sticky; bit0 RAS overflow, bit1 RAS underflow

Behaviour:
- Reset (input_rst_n=0 at a rising edge) overrides everything, including a mid-sequence update:
  - output_PC=RESET_PC, RAS count=0, top pointer=0, output_taken=0, output_fault=0.
  - RAS entry contents are don't-care after reset.
- Derived values, all arithmetic modulo 2^WIDTH:
  - seq = PC+STEP, wrapping (0xFFFE+2 -> 0x0000 at defaults).
  - target = (input_newPC << TARGET_SHIFT) truncated to WIDTH.
- Branch condition cond:
  - beq: zero
  - bne: !zero
  - blt: negative
  - bge: !negative
- input_PCWrite=0: PC, RAS, count and faults hold; output_taken<=0.
- input_PCWrite=1, one-cycle latency (new PC visible after the edge):
  - SEQ: PC<=seq; taken<=0.
  - BRANCH: PC<=cond?target:seq; taken<=cond.
  - JUMP: PC<=target; taken<=1.
  - CALL: push seq; PC<=target; taken<=1.
    - Push writes RAS[ptr], then ptr<=(ptr+1) mod RAS_DEPTH.
    - Count increments, saturating at RAS_DEPTH.
    - If already full: the oldest entry is overwritten (circular), count stays RAS_DEPTH, fault[0]<=1.
  - RET, not empty: ptr<=(ptr-1) mod RAS_DEPTH; PC<=RAS[ptr-1]; count-1; taken<=1.
  - RET, empty: PC<=seq; count stays 0; fault[1]<=1; taken<=0.
  - Reserved ops: behave as SEQ; no fault.
- Fault bits are sticky and cleared only by reset.
- Pops after an overflow return entries newest-first. After RAS_DEPTH pops the stack is empty, and the next RET is an underflow.
- Combinational outputs (full, empty) must have no combinational path from inputs; they depend only on registered count.

Test Plan:
- Reset, then 3 cycles of PCWrite=1 SEQ -> PC 0x0000, 0x0002, 0x0004, 0x0006; taken=0. Then PCWrite=0 for 2 cycles -> PC holds 0x0006.
- PC=0x0010:
  - BRANCH beq with zero=1, newPC=0x1234 -> PC=0x2468, taken=1 next cycle.
  - Then BRANCH bne with zero=1 -> PC=0x246A, taken=0.
  - Then blt with negative=1, newPC=0x0100 -> PC=0x0200.
- PC at 0xFFFE, SEQ -> PC=0x0000 (wrap), no fault.
- From PC=0x0100:
  - CALL newPC=0x0200 -> PC=0x0400, count=1, RAS top 0x0102.
  - CALL newPC=0x0300 -> PC=0x0600, count=2.
  - RET -> PC=0x0402; RET -> PC=0x0102; count=0, empty=1.
- Overflow: 5 CALLs from PC=0x0000 with newPC=0x10,0x20,0x30,0x40,0x50.
  - After the 5th: full=1, count=4, fault=01.
  - 4 RETs -> PC=0x0082, 0x0062, 0x0042, 0x0022.
  - 5th RET -> PC=0x0024, fault=11, count=0.
- Assert reset for one edge in the middle of a CALL sequence (count=2) -> PC=0x0000, count=0, fault=00, taken=0. The next RET underflows (fault=10).
